// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Hazard controller for a 5-stage in-order pipeline. It detects load-use
//   hazards, outstanding data-memory waits and control-transfer redirects, and
//   drives the per-stage stall, decode-squash and fetch-flush controls. It also
//   keeps two saturating performance counters (stall cycles, squash cycles).
//
// Ports
//   clk, rst_i                      clock, asynchronous active-high reset
//   id_valid_i                      IF/ID holds a valid instruction
//   id_rs1_addr_i, id_rs2_addr_i    ID source register addresses
//   id_uses_rs1_i, id_uses_rs2_i    ID instruction reads rs1 / rs2
//   id_ctrl_xfer_i                  ID resolves a redirect
//   ex_valid_i, ex_dmem_rd_en_i     ID/EX valid, ID/EX instruction is a load
//   ex_reg_wr_addr_i                ID/EX destination register
//   dmem_req_i, dmem_ready_i        MEM access pending / completes this cycle
//   cnt_clr_i                       synchronous clear of both counters
//   stall_{if,id,ex,mem}_o          hold PC+IF/ID, ID/EX, EX/MEM, MEM/WB
//   squash_id_o                     insert a bubble into ID/EX
//   flush_if_o                      invalidate IF/ID on the next edge
//   state_o                         FSM state (RUN=0, LOAD_USE=1, MEM_WAIT=2)
//   stall_cnt_o, squash_cnt_o       saturating performance counters
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic             id_ctrl_xfer_i,
  input  logic             ex_valid_i,
  input  logic             ex_dmem_rd_en_i,
  input  logic [4:0]       ex_reg_wr_addr_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  input  logic             cnt_clr_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_ex_o,
  output logic             stall_mem_o,
  output logic             squash_id_o,
  output logic             flush_if_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] squash_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LOAD_USE = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

  logic mem_wait;
  logic load_use_raw;
  logic load_use;
  logic stall_if_s, stall_back_s, squash_s, flush_s;

  // Raw hazard terms, independent of FSM state.
  always_comb begin
    mem_wait     = dmem_req_i & ~dmem_ready_i;
    load_use_raw = id_valid_i & ex_valid_i & ex_dmem_rd_en_i &
                   (ex_reg_wr_addr_i != 5'd0) &
                   ((id_uses_rs1_i & (id_rs1_addr_i == ex_reg_wr_addr_i)) |
                    (id_uses_rs2_i & (id_rs2_addr_i == ex_reg_wr_addr_i)));
  end

  // Next-state and control decode. The MEM_WAIT exit cycle behaves like RUN,
  // so a load-use hazard held behind a memory wait takes its bubble there.
  // LOAD_USE masks detection: the bubble already sits in ID/EX.
  always_comb begin
    state_d      = ST_RUN;
    load_use     = 1'b0;
    stall_if_s   = 1'b0;
    stall_back_s = 1'b0;
    squash_s     = 1'b0;
    flush_s      = 1'b0;
    case (state_q)
      ST_RUN:      load_use = load_use_raw;
      ST_MEM_WAIT: load_use = load_use_raw;
      ST_LOAD_USE: load_use = 1'b0;
      default:     load_use = 1'b0;
    endcase
    if (mem_wait) begin
      stall_if_s   = 1'b1;
      stall_back_s = 1'b1;
      state_d      = ST_MEM_WAIT;
    end else if (load_use) begin
      stall_if_s   = 1'b1;
      squash_s     = 1'b1;
      state_d      = ST_LOAD_USE;
    end else begin
      flush_s      = id_ctrl_xfer_i & id_valid_i;
      state_d      = ST_RUN;
    end
  end

  // Outputs are forced quiet while reset is held, independent of the clock.
  always_comb begin
    stall_if_o   = stall_if_s   & ~rst_i;
    stall_id_o   = stall_back_s & ~rst_i;
    stall_ex_o   = stall_back_s & ~rst_i;
    stall_mem_o  = stall_back_s & ~rst_i;
    squash_id_o  = squash_s     & ~rst_i;
    flush_if_o   = flush_s      & ~rst_i;
    state_o      = state_q;
    stall_cnt_o  = stall_cnt_q;
    squash_cnt_o = squash_cnt_q;
  end

  // Saturating counters; clear wins over increment.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (cnt_clr_i) begin
      stall_cnt_d  = '0;
      squash_cnt_d = '0;
    end else begin
      if (stall_if_s && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if ((squash_s || flush_s) && (squash_cnt_q != CNT_MAX)) begin
        squash_cnt_d = squash_cnt_q + CNT_ONE;
      end else begin
        squash_cnt_d = squash_cnt_q;
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      stall_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed bench for pipeline_hazard_ctrl (CNT_W = 8). A cycle-level model
//   derived from the hazard rules predicts every output and is compared with
//   the DUT on each falling edge; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_uses_rs1, id_uses_rs2, id_ctrl_xfer;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          ex_valid, ex_ld, dreq, drdy, cnt_clr;
  logic          stall_if, stall_id, stall_ex, stall_mem, squash_id, flush_if;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt, squash_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_i(rst),
    .id_valid_i(id_valid), .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2),
    .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
    .id_ctrl_xfer_i(id_ctrl_xfer), .ex_valid_i(ex_valid),
    .ex_dmem_rd_en_i(ex_ld), .ex_reg_wr_addr_i(ex_rd),
    .dmem_req_i(dreq), .dmem_ready_i(drdy), .cnt_clr_i(cnt_clr),
    .stall_if_o(stall_if), .stall_id_o(stall_id), .stall_ex_o(stall_ex),
    .stall_mem_o(stall_mem), .squash_id_o(squash_id), .flush_if_o(flush_if),
    .state_o(state), .stall_cnt_o(stall_cnt), .squash_cnt_o(squash_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_bubble: the previous edge inserted a load-use bubble, so the hazard now
  // seen in ID is already resolved. m_mwait: previous cycle was a memory wait.
  int m_stalls = 0, m_squashes = 0, n_stalls = 0, n_squashes = 0;
  bit m_bubble = 0, m_mwait = 0, n_bubble = 0, n_mwait = 0;

  always @(negedge clk) begin
    bit mw, lu, fl, hit;
    int exp_state;
    if (!rst) begin
      mw  = dreq && !drdy;
      hit = (id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd);
      lu  = !mw && !m_bubble && id_valid && ex_valid && ex_ld && ex_rd != 0 && hit;
      fl  = !mw && !lu && id_ctrl_xfer && id_valid;
      exp_state = m_mwait ? 2 : (m_bubble ? 1 : 0);
      chk("m_state",     state,     exp_state);
      chk("m_stall_if",  stall_if,  int'(mw || lu));
      chk("m_stall_id",  stall_id,  int'(mw));
      chk("m_stall_ex",  stall_ex,  int'(mw));
      chk("m_stall_mem", stall_mem, int'(mw));
      chk("m_squash",    squash_id, int'(lu));
      chk("m_flush",     flush_if,  int'(fl));
      chk("m_stall_cnt", stall_cnt, m_stalls);
      chk("m_squash_cnt",squash_cnt,m_squashes);
      n_mwait    = mw;
      n_bubble   = lu;
      n_stalls   = cnt_clr ? 0 : ((mw || lu) ? ((m_stalls < MAXC) ? m_stalls + 1 : MAXC) : m_stalls);
      n_squashes = cnt_clr ? 0 : ((lu || fl) ? ((m_squashes < MAXC) ? m_squashes + 1 : MAXC) : m_squashes);
    end else begin
      n_mwait = 0; n_bubble = 0; n_stalls = 0; n_squashes = 0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mwait = 0; m_bubble = 0; m_stalls = 0; m_squashes = 0;
    end else begin
      m_mwait = n_mwait; m_bubble = n_bubble;
      m_stalls = n_stalls; m_squashes = n_squashes;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    id_valid = 1'b0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_ctrl_xfer = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; ex_valid = 1'b0; ex_ld = 1'b0;
    dreq = 1'b0; drdy = 1'b0; cnt_clr = 1'b0;
  endtask

  // Advance to just after the next rising edge, then leave a settle gap.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_x5();
    ex_valid = 1'b1; ex_ld = 1'b1; ex_rd = 5'd5;
    id_valid = 1'b1; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    id_rs1 = 5'd3; id_rs2 = 5'd5;
  endtask

  task automatic clear_cnts();
    idle(); cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    dreq = 1'b1;                     // hazard present but reset forces quiet
    #2;
    chk("rst_stall_if", stall_if, 0);
    chk("rst_stall_mem", stall_mem, 0);
    chk("rst_state", state, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    #10 rst = 1'b0;                  // release between edges (t=12)
    idle();
    tick();

    // Load-use on rs2 = x5: one bubble cycle, then RUN with counters at 1.
    clear_cnts();
    load_use_x5();
    #1;
    chk("lu_stall_if", stall_if, 1);
    chk("lu_squash", squash_id, 1);
    chk("lu_stall_id", stall_id, 0);
    tick();
    chk("lu_state", state, 1);
    idle(); tick();
    chk("lu_state_run", state, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_squash_cnt", squash_cnt, 1);

    // Load to x0, ID reads x0: nothing happens.
    ex_valid = 1'b1; ex_ld = 1'b1; ex_rd = 5'd0;
    id_valid = 1'b1; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    #1;
    chk("x0_stall_if", stall_if, 0);
    chk("x0_squash", squash_id, 0);
    tick(); idle(); #1;
    chk("x0_stall_cnt", stall_cnt, 1);
    chk("x0_squash_cnt", squash_cnt, 1);

    // Plain redirect.
    clear_cnts();
    id_valid = 1'b1; id_ctrl_xfer = 1'b1;
    #1;
    chk("jmp_flush", flush_if, 1);
    chk("jmp_stall_if", stall_if, 0);
    tick(); idle(); #1;
    chk("jmp_squash_cnt", squash_cnt, 1);
    chk("jmp_flush_off", flush_if, 0);

    // Memory wait x3 coincident with load-use and redirect.
    clear_cnts();
    load_use_x5(); id_ctrl_xfer = 1'b1; dreq = 1'b1; drdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_stall_if", stall_if, 1);
      chk("mw_stall_mem", stall_mem, 1);
      chk("mw_squash", squash_id, 0);
      chk("mw_flush", flush_if, 0);
      tick();
    end
    drdy = 1'b1;                     // access completes this cycle
    #1;
    chk("mw_exit_state", state, 2);
    chk("mw_stall_cnt", stall_cnt, 3);
    chk("mw_exit_bubble", squash_id, 1);
    chk("mw_exit_stall_mem", stall_mem, 0);
    chk("mw_exit_flush", flush_if, 0);
    tick(); dreq = 1'b0; #1;
    chk("mw_lu_state", state, 1);
    chk("mw_lu_flush", flush_if, 1); // redirect re-evaluated once bubble taken
    tick(); idle(); tick();

    // Saturation at 255 and clear with a coincident stall.
    clear_cnts();
    dreq = 1'b1; drdy = 1'b0;
    for (int i = 0; i < 260; i++) tick();
    chk("sat_stall_cnt", stall_cnt, 255);
    cnt_clr = 1'b1;
    tick();
    chk("sat_clr", stall_cnt, 0);
    cnt_clr = 1'b0;
    tick(); tick();

    // Reset between edges during MEM_WAIT.
    chk("rst_pre_state", state, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_stall_if", stall_if, 0);
    chk("arst_stall_ex", stall_ex, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_squash_cnt", squash_cnt, 0);
    @(negedge clk); #2 rst = 1'b0;
    idle(); tick();
    chk("post_rst_state", state, 0);

    // Random-ish mix checked only by the model.
    for (int i = 0; i < 200; i++) begin
      id_valid = 1'($urandom_range(0, 1)); id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1)); id_ctrl_xfer = 1'($urandom_range(0, 1));
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); ex_valid = 1'($urandom_range(0, 1));
      ex_ld = 1'($urandom_range(0, 1)); dreq = ($urandom_range(0, 3) == 0);
      drdy = 1'($urandom_range(0, 1)); cnt_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    idle(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
